// File: rtl/rggen_counter_event_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// rggen_counter_sched_pkg
// Shared types and helpers for the counter event scheduler.
//   - sched_state_e : per-channel clear-sequencing FSM state
//   - sat_add       : pending update, clamped to [lo, hi]
//   - sat_clips     : flags when the same update had to be clamped
// The arithmetic runs at SAT_CALC_W bits, wide enough for any pending width
// (up to 8 bits) plus the worst-case step of +/-2 in one cycle.
// Signed/unsigned pending selection is made by the caller through the bounds
// it passes (see RGGEN_COUNTER_SCHED_DOWN_EN in the channel module).
// ---------------------------------------------------------------------------
package rggen_counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLR_WAIT  = 2'd1,
    CLR_ISSUE = 2'd2
  } sched_state_e;

  localparam int SAT_CALC_W = 12;

  function automatic logic signed [SAT_CALC_W-1:0] sat_add(
    input logic signed [SAT_CALC_W-1:0] cur,
    input logic signed [SAT_CALC_W-1:0] delta,
    input logic signed [SAT_CALC_W-1:0] lo,
    input logic signed [SAT_CALC_W-1:0] hi
  );
    logic signed [SAT_CALC_W-1:0] sum;
    sum = cur + delta;
    if (sum > hi)      sat_add = hi;
    else if (sum < lo) sat_add = lo;
    else               sat_add = sum;
  endfunction

  function automatic logic sat_clips(
    input logic signed [SAT_CALC_W-1:0] cur,
    input logic signed [SAT_CALC_W-1:0] delta,
    input logic signed [SAT_CALC_W-1:0] lo,
    input logic signed [SAT_CALC_W-1:0] hi
  );
    logic signed [SAT_CALC_W-1:0] sum;
    sum = cur + delta;
    sat_clips = (sum > hi) || (sum < lo);
  endfunction

endpackage

// File: rtl/rggen_counter_event_scheduler_if.sv
// ---------------------------------------------------------------------------
// rggen_counter_event_scheduler_if
// Bundles the event inputs and counter-side outputs of the scheduler.
//   i_enable      : global dispense enable
//   i_event_up    : per-channel increment event pulse
//   i_event_down  : per-channel decrement event pulse
//   i_clear_req   : per-channel clear request pulse
//   i_sw_write    : per-channel software write in progress
//   o_up/o_down   : one step per cycle to the counter
//   o_clear       : clear strobe to the counter
//   o_overflow    : sticky, pending accumulator saturated
//   o_busy        : pending non-zero or clear outstanding
// master = event source / counter side, slave = scheduler.
// Optional feature macro: RGGEN_COUNTER_SCHED_DOWN_EN (affects the scheduler).
// ---------------------------------------------------------------------------
interface rggen_counter_event_scheduler_if #(
  parameter int CHANNELS = 4
);
  logic                i_enable;
  logic [CHANNELS-1:0] i_event_up;
  logic [CHANNELS-1:0] i_event_down;
  logic [CHANNELS-1:0] i_clear_req;
  logic [CHANNELS-1:0] i_sw_write;
  logic [CHANNELS-1:0] o_up;
  logic [CHANNELS-1:0] o_down;
  logic [CHANNELS-1:0] o_clear;
  logic [CHANNELS-1:0] o_overflow;
  logic [CHANNELS-1:0] o_busy;

  modport master (
    output i_enable, i_event_up, i_event_down, i_clear_req, i_sw_write,
    input  o_up, o_down, o_clear, o_overflow, o_busy
  );

  modport slave (
    input  i_enable, i_event_up, i_event_down, i_clear_req, i_sw_write,
    output o_up, o_down, o_clear, o_overflow, o_busy
  );
endinterface

// File: rtl/rggen_counter_event_scheduler_channel.sv
// ---------------------------------------------------------------------------
// rggen_counter_sched_channel
// One scheduler channel: net-pending accumulator, sticky overflow and the
// clear-sequencing FSM (IDLE / CLR_WAIT / CLR_ISSUE).
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_enable          : dispense enable (events still accumulate when low)
//   i_event_up/down   : event pulses
//   i_clear_req       : clear request pulse
//   i_sw_write        : software write in progress (stalls dispense/clear)
//   o_up/o_down       : step strobes, never high together
//   o_clear           : one-cycle clear strobe
//   o_overflow        : sticky saturation flag
//   o_busy            : pending != 0 or clear outstanding
// Macro RGGEN_COUNTER_SCHED_DOWN_EN: when defined, pending is signed and
// down events are honoured; otherwise pending is unsigned, down is ignored
// and o_down is tied low.
// ---------------------------------------------------------------------------
module rggen_counter_sched_channel
  import rggen_counter_sched_pkg::*;
#(
  parameter int PENDING_WIDTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_event_up,
  input  logic i_event_down,
  input  logic i_clear_req,
  input  logic i_sw_write,
  output logic o_up,
  output logic o_down,
  output logic o_clear,
  output logic o_overflow,
  output logic o_busy
);

`ifdef RGGEN_COUNTER_SCHED_DOWN_EN
  localparam int P_LO_I = -(2 ** (PENDING_WIDTH - 1));
  localparam int P_HI_I = (2 ** (PENDING_WIDTH - 1)) - 1;
`else
  localparam int P_LO_I = 0;
  localparam int P_HI_I = (2 ** PENDING_WIDTH) - 1;
`endif
  localparam logic signed [SAT_CALC_W-1:0] P_LO = SAT_CALC_W'(P_LO_I);
  localparam logic signed [SAT_CALC_W-1:0] P_HI = SAT_CALC_W'(P_HI_I);

  sched_state_e               r_state;
  logic [PENDING_WIDTH-1:0]   r_pending;
  logic                       r_overflow;

  logic                       w_stall;
  logic                       w_pos;
  logic                       w_neg;
  logic                       w_down_in;
  logic signed [SAT_CALC_W-1:0] w_cur;
  logic signed [SAT_CALC_W-1:0] w_delta;
  logic [PENDING_WIDTH-1:0]   w_next;
  logic                       w_clip;

`ifdef RGGEN_COUNTER_SCHED_DOWN_EN
  assign w_down_in = i_event_down;
  assign w_cur     = {{(SAT_CALC_W-PENDING_WIDTH){r_pending[PENDING_WIDTH-1]}}, r_pending};
  assign w_pos     = !r_pending[PENDING_WIDTH-1] && (|r_pending);
  assign w_neg     = r_pending[PENDING_WIDTH-1];
`else
  logic w_unused_down;
  assign w_unused_down = i_event_down;
  assign w_down_in     = 1'b0;
  assign w_cur         = {{(SAT_CALC_W-PENDING_WIDTH){1'b0}}, r_pending};
  assign w_pos         = |r_pending;
  assign w_neg         = 1'b0;
`endif

  // Any non-IDLE state blocks dispense so no step races the clear.
  assign w_stall = !i_enable || i_sw_write || (r_state != IDLE);
  assign o_up    = !w_stall && w_pos;
  assign o_down  = !w_stall && w_neg;

  // Net change: events in, minus the step handed to the counter this cycle.
  always_comb begin
    w_delta = '0;
    if (i_event_up) w_delta = w_delta + SAT_CALC_W'(1);
    if (w_down_in)  w_delta = w_delta - SAT_CALC_W'(1);
    if (o_up)       w_delta = w_delta - SAT_CALC_W'(1);
    if (o_down)     w_delta = w_delta + SAT_CALC_W'(1);
  end

  assign w_next = PENDING_WIDTH'(sat_add(w_cur, w_delta, P_LO, P_HI));
  assign w_clip = sat_clips(w_cur, w_delta, P_LO, P_HI);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_clear_req) begin
            // Events in the request cycle are dropped along with the backlog.
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_state    <= i_sw_write ? CLR_WAIT : CLR_ISSUE;
          end else begin
            r_pending <= w_next;
            if (w_clip) r_overflow <= 1'b1;
          end
        end
        CLR_WAIT: begin
          if (!i_sw_write) r_state <= CLR_ISSUE;
        end
        CLR_ISSUE: begin
          // A write landing on the clear cycle wins at the counter, so retry.
          r_state <= i_sw_write ? CLR_WAIT : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_clear    = (r_state == CLR_ISSUE);
  assign o_overflow = r_overflow;
  assign o_busy     = (|r_pending) || (r_state != IDLE);

endmodule

// File: rtl/rggen_counter_event_scheduler.sv
// ---------------------------------------------------------------------------
// rggen_counter_event_scheduler
// Sequencing front-end for a bank of rggen_bit_field_counter instances.
// Accumulates per-channel net event counts, dispenses at most one up/down
// step per channel per cycle and sequences clears around software writes.
// Ports:
//   i_clk : clock
//   i_rst : asynchronous active-high reset
//   bus   : rggen_counter_event_scheduler_if.slave (events in, steps out)
// Parameters: CHANNELS (1..32), PENDING_WIDTH (2..8).
// Macro RGGEN_COUNTER_SCHED_DOWN_EN enables signed up/down accumulation;
// without it the bank is up-only with an unsigned accumulator.
// ---------------------------------------------------------------------------
module rggen_counter_event_scheduler
  import rggen_counter_sched_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int PENDING_WIDTH = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  rggen_counter_event_scheduler_if.slave        bus
);

  logic [CHANNELS-1:0] w_enable;
  logic [CHANNELS-1:0] w_up;
  logic [CHANNELS-1:0] w_down;
  logic [CHANNELS-1:0] w_clear;
  logic [CHANNELS-1:0] w_overflow;
  logic [CHANNELS-1:0] w_busy;

  assign w_enable = {CHANNELS{bus.i_enable}};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    rggen_counter_sched_channel #(
      .PENDING_WIDTH (PENDING_WIDTH)
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_enable     (w_enable[g]),
      .i_event_up   (bus.i_event_up[g]),
      .i_event_down (bus.i_event_down[g]),
      .i_clear_req  (bus.i_clear_req[g]),
      .i_sw_write   (bus.i_sw_write[g]),
      .o_up         (w_up[g]),
      .o_down       (w_down[g]),
      .o_clear      (w_clear[g]),
      .o_overflow   (w_overflow[g]),
      .o_busy       (w_busy[g])
    );
  end

  assign bus.o_up       = w_up;
  assign bus.o_down     = w_down;
  assign bus.o_clear    = w_clear;
  assign bus.o_overflow = w_overflow;
  assign bus.o_busy     = w_busy;

endmodule

// File: tb/tb_rggen_counter_event_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for rggen_counter_event_scheduler (CHANNELS=4, PENDING_WIDTH=4).
// Expected values follow the RGGEN_COUNTER_SCHED_DOWN_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_rggen_counter_event_scheduler;

`ifdef RGGEN_COUNTER_SCHED_DOWN_EN
  localparam int PMAX = 7;
`else
  localparam int PMAX = 15;
`endif

  typedef struct {
    logic       en;
    logic [3:0] up, dn, clr, sw;
    logic [3:0] eup, edn, eclr, eovf, ebusy;
  } vec_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];

  rggen_counter_event_scheduler_if #(.CHANNELS(4)) bus ();

  rggen_counter_event_scheduler #(
    .CHANNELS      (4),
    .PENDING_WIDTH (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eup, input logic [3:0] edn,
                         input logic [3:0] eclr, input logic [3:0] eovf, input logic [3:0] ebusy);
    chk({tag, ".up"},       bus.o_up,       eup);
    chk({tag, ".down"},     bus.o_down,     edn);
    chk({tag, ".clear"},    bus.o_clear,    eclr);
    chk({tag, ".overflow"}, bus.o_overflow, eovf);
    chk({tag, ".busy"},     bus.o_busy,     ebusy);
  endtask

  // Drive one cycle's inputs after the falling edge, settle, then compare.
  task automatic step(input logic en, input logic [3:0] up, input logic [3:0] dn,
                      input logic [3:0] clr, input logic [3:0] sw);
    @(negedge clk);
    bus.i_enable     = en;
    bus.i_event_up   = up;
    bus.i_event_down = dn;
    bus.i_clear_req  = clr;
    bus.i_sw_write   = sw;
    #1;
  endtask

  function automatic void add(input logic en, input logic [3:0] up, input logic [3:0] dn,
                              input logic [3:0] clr, input logic [3:0] sw,
                              input logic [3:0] eup, input logic [3:0] eovf,
                              input logic [3:0] ebusy);
    vec_t v;
    v.en = en; v.up = up; v.dn = dn; v.clr = clr; v.sw = sw;
    v.eup = eup; v.edn = 4'b0; v.eclr = 4'b0; v.eovf = eovf; v.ebusy = ebusy;
    tbl.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_enable = 1'b0; bus.i_event_up = '0; bus.i_event_down = '0;
    bus.i_clear_req = '0; bus.i_sw_write = '0;
    #1;
    chk_all("reset", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ovf2;
    int         nup;

    // ---- table: ch0 burst of 3 ----
    add(1, 4'b0001, 0, 0, 0, 4'b0000, 0, 4'b0000);
    add(1, 4'b0001, 0, 0, 0, 4'b0001, 0, 4'b0001);
    add(1, 4'b0001, 0, 0, 0, 4'b0001, 0, 4'b0001);
    add(1, 4'b0000, 0, 0, 0, 4'b0001, 0, 4'b0001);
    add(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000);
    // ---- table: ch1 simultaneous up+down for 5 cycles ----
`ifdef RGGEN_COUNTER_SCHED_DOWN_EN
    for (int k = 0; k < 5; k++) add(1, 4'b0010, 4'b0010, 0, 0, 4'b0000, 0, 4'b0000);
    add(1, 0, 0, 0, 0, 4'b0000, 0, 4'b0000);
`else
    add(1, 4'b0010, 4'b0010, 0, 0, 4'b0000, 0, 4'b0000);
    for (int k = 0; k < 4; k++) add(1, 4'b0010, 4'b0010, 0, 0, 4'b0010, 0, 4'b0010);
    add(1, 0, 0, 0, 0, 4'b0010, 0, 4'b0010);
    add(1, 0, 0, 0, 0, 4'b0000, 0, 4'b0000);
`endif
    // ---- table: ch2, 10 up pulses with dispense disabled, then release ----
    for (int k = 1; k <= 10; k++)
      add(0, 4'b0100, 0, 0, 0, 4'b0000, (k >= PMAX + 2) ? 4'b0100 : 4'b0000,
          (k > 1) ? 4'b0100 : 4'b0000);
    ovf2 = (10 > PMAX) ? 4'b0100 : 4'b0000;
    nup  = (10 > PMAX) ? PMAX : 10;
    for (int k = 0; k < nup; k++) add(1, 0, 0, 0, 0, 4'b0100, ovf2, 4'b0100);
    add(1, 0, 0, 0, 0, 4'b0000, ovf2, 4'b0000);

    rst = 1'b1;
    bus.i_enable = 1'b0; bus.i_event_up = '0; bus.i_event_down = '0;
    bus.i_clear_req = '0; bus.i_sw_write = '0;
    #12;
    chk_all("por", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].up, tbl[i].dn, tbl[i].clr, tbl[i].sw);
      chk_all($sformatf("vec%0d", i), tbl[i].eup, tbl[i].edn, tbl[i].eclr,
              tbl[i].eovf, tbl[i].ebusy);
    end

    do_reset();

    // ---- ch3: saturate, then clear held off by a 4-cycle software write ----
    for (int k = 0; k <= PMAX; k++) step(0, 4'b1000, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("c3.ovf_set", bus.o_overflow, 4'b1000);
    chk("c3.busy_set", bus.o_busy, 4'b1000);
    step(1, 4'b1000, 0, 4'b1000, 4'b1000);
    chk("c3.req_clear", bus.o_clear, 4'b0000);
    chk("c3.req_up", bus.o_up, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step(1, 4'b1000, 0, 0, 4'b1000);
      chk($sformatf("c3.wait%0d_clear", k), bus.o_clear, 4'b0000);
      chk($sformatf("c3.wait%0d_ovf", k), bus.o_overflow, 4'b0000);
      chk($sformatf("c3.wait%0d_busy", k), bus.o_busy, 4'b1000);
    end
    step(1, 4'b1000, 0, 0, 0);
    chk("c3.drop_clear", bus.o_clear, 4'b0000);
    step(1, 0, 0, 0, 0);
    chk("c3.issue_clear", bus.o_clear, 4'b1000);
    chk("c3.issue_up", bus.o_up, 4'b0000);
    step(1, 0, 0, 0, 0);
    chk_all("c3.done", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

    // ---- ch1: unblocked clear, repeat request absorbed, events discarded ----
    step(1, 4'b0010, 0, 4'b0010, 0);
    chk("c1.req_clear", bus.o_clear, 4'b0000);
    step(1, 4'b0010, 0, 4'b0010, 0);
    chk("c1.issue_clear", bus.o_clear, 4'b0010);
    step(1, 4'b0010, 0, 0, 0);
    chk_all("c1.n2", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    step(1, 0, 0, 0, 0);
    chk_all("c1.n3", 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0010);
    step(1, 0, 0, 0, 0);
    chk_all("c1.n4", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

    // ---- ch1: write arrives on the clear cycle -> retry ----
    step(1, 0, 0, 4'b0010, 0);
    step(1, 0, 0, 0, 4'b0010);
    chk("c1r.issue1", bus.o_clear, 4'b0010);
    step(1, 0, 0, 0, 0);
    chk("c1r.wait", bus.o_clear, 4'b0000);
    chk("c1r.wait_busy", bus.o_busy, 4'b0010);
    step(1, 0, 0, 0, 0);
    chk("c1r.issue2", bus.o_clear, 4'b0010);
    step(1, 0, 0, 0, 0);
    chk_all("c1r.done", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

    // ---- ch0: software write stalls dispense of 2 pending steps ----
    step(0, 4'b0001, 0, 0, 0);
    step(0, 4'b0001, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 4'b0001);
      chk($sformatf("sw%0d.up", k), bus.o_up, 4'b0000);
      chk($sformatf("sw%0d.busy", k), bus.o_busy, 4'b0001);
    end
    step(1, 0, 0, 0, 0);
    chk("sw.up1", bus.o_up, 4'b0001);
    step(1, 0, 0, 0, 0);
    chk("sw.up2", bus.o_up, 4'b0001);
    step(1, 0, 0, 0, 0);
    chk_all("sw.done", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

    // ---- ch0: down events ----
    step(1, 0, 4'b0001, 0, 0);
    chk_all("dn.c1", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
`ifdef RGGEN_COUNTER_SCHED_DOWN_EN
    step(1, 0, 4'b0001, 0, 0);
    chk_all("dn.c2", 4'b0, 4'b0001, 4'b0, 4'b0, 4'b0001);
    step(1, 0, 0, 0, 0);
    chk_all("dn.c3", 4'b0, 4'b0001, 4'b0, 4'b0, 4'b0001);
`else
    step(1, 0, 4'b0001, 0, 0);
    chk_all("dn.c2", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    step(1, 0, 0, 0, 0);
    chk_all("dn.c3", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
`endif
    step(1, 0, 0, 0, 0);
    chk_all("dn.c4", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

    // ---- ch0: asynchronous reset in the middle of a burst ----
    step(1, 4'b0001, 0, 0, 0);
    step(1, 4'b0001, 0, 0, 0);
    chk("rb.up_a", bus.o_up, 4'b0001);
    step(1, 4'b0001, 0, 0, 0);
    chk("rb.up_b", bus.o_up, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rb.async", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    bus.i_event_up = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0);
      chk_all($sformatf("rb.after%0d", k), 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rggen_counter_event_scheduler.md
# rggen_counter_event_scheduler

Sequencing front-end for a bank of `rggen_bit_field_counter` instances. It accepts bursty, possibly simultaneous up/down event pulses and clear requests from CHANNELS hardware sources. It accumulates the net step count per channel and dispenses at most one `i_up`/`i_down` step per channel per cycle. It also sequences clears around software register writes so that no step or clear is lost to the counter's write priority.

## Interface
- CHANNELS, 4: number of counter channels (1..32).
- PENDING_WIDTH, 4: width of the signed per-channel net-pending accumulator (2..8).
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_enable  input  1  global dispense enable; events still accumulate while low.
- i_event_up  input  CHANNELS  per-channel increment event pulse.
- i_event_down  input  CHANNELS  per-channel decrement event pulse.
- i_clear_req  input  CHANNELS  per-channel clear request pulse.
- i_sw_write  input  CHANNELS  per-channel software write in progress (counter's valid && |write_mask).
- o_up  output  CHANNELS  to counter i_up.
- o_down  output  CHANNELS  to counter i_down.
- o_clear  output  CHANNELS  to counter i_clear.
- o_overflow  output  CHANNELS  sticky: pending accumulator saturated.
- o_busy  output  CHANNELS  pending != 0 or clear outstanding.

## Operation
- Per channel, `pending` is signed PENDING_WIDTH (range -2^(W-1)..2^(W-1)-1). It resets to 0.
- Per-channel FSM:
  - IDLE: normal dispense.
  - CLR_WAIT: clear requested, blocked by i_sw_write.
  - CLR_ISSUE: o_clear high.
- Dispense, combinational from state: `stall = !i_enable | i_sw_write | (state != IDLE)`.
  - o_up = !stall & pending > 0.
  - o_down = !stall & pending < 0.
  - o_up and o_down are never high together.
- Update at each edge in IDLE: pending_next = pending + up_in - down_in - o_up + o_down, saturated to the range.
  - Simultaneous up and down events cancel.
  - Saturation drops the excess and sets o_overflow (sticky).
- Clear:
  - i_clear_req in IDLE moves to CLR_ISSUE if i_sw_write is low, else to CLR_WAIT.
  - CLR_WAIT moves to CLR_ISSUE on the first cycle with i_sw_write low.
  - CLR_ISSUE lasts exactly one cycle, then returns to IDLE.
  - pending and o_overflow go to 0 on entry to CLR_WAIT/CLR_ISSUE. Events arriving in the request cycle are discarded.
  - Events arriving during CLR_WAIT/CLR_ISSUE are discarded.
  - In CLR_ISSUE, if i_sw_write rises, go back to CLR_WAIT and retry.
- i_clear_req while not IDLE is absorbed: no second clear.
- o_busy = (pending != 0) | (state != IDLE).
- Reset values: o_up = o_down = o_clear = o_overflow = o_busy = 0, state IDLE.

## Timing
- Event pulse in cycle N: pending is updated at the edge ending N, and o_up/o_down are first visible in N+1 (1-cycle latency).
- Burst of K up events with no stall: o_up is high for exactly K consecutive cycles, starting one cycle after the first event, for K ≤ 2^(W-1)-1.
- Clear request in cycle N with i_sw_write low in N and N+1: o_clear is high in N+1 only. The first dispense is possible in N+2.
- Asynchronous reset mid-operation: all state clears immediately and outputs drop in the same cycle.

## Configuration
- RGGEN_COUNTER_SCHED_DOWN_EN defined: full up/down behaviour as above.
- Not defined:
  - i_event_down is ignored.
  - o_down is tied 0.
  - pending is unsigned over the same width (0..2^W-1), saturating at the top.

## Structure
- Package `rggen_counter_sched_pkg`:
  - FSM state enum (IDLE, CLR_WAIT, CLR_ISSUE).
  - Saturate-add function for the pending update.
- Sub-module `rggen_counter_sched_channel`: one per channel, holds the FSM, pending and overflow. The top level is a generate loop plus fan-out of i_enable.

## Test plan
- Reset, W=4, ch0: 3 up pulses in cycles 1-3 → o_up[0] high cycles 2-4, then o_busy[0]=0.
- Simultaneous up+down on ch1 for 5 cycles → no o_up/o_down, pending stays 0.
- 10 back-to-back up pulses on ch2 with i_enable=0 → pending saturates at 7, o_overflow[2]=1. Raise i_enable → exactly 7 o_up cycles.
- Clear on ch3 with i_sw_write[3] high for 4 cycles → o_clear[3] held off, then asserted for 1 cycle after write drops. o_overflow cleared, pending 0.
- i_sw_write during dispense on ch0 with pending=2 → o_up suppressed while high, both steps delivered afterwards.
- Assert i_rst mid-burst → outputs 0 immediately. After release, no residual steps are issued.
